// File: rtl/tdma_burst_scheduler.sv
// GSM TDMA timebase (quarter-bit / timeslot / frame number) and the burst sequencer
// that ramps the PA, fires the burst controller and holds the PA through the tail.
module tdma_burst_scheduler #(
  parameter int CLOCKS_PER_QBIT = 12,
  parameter int RAMP_TAIL       = 8,
  parameter int START_TIMEOUT   = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  slot_mask,
  input  logic [9:0]  fire_offset,
  input  logic [7:0]  ramp_lead,
  input  logic        armed,
  input  logic        iq_valid,
  output logic        fire_burst,
  output logic        pa_en,
  output logic        qbit_strobe,
  output logic [9:0]  qbit,
  output logic [2:0]  timeslot,
  output logic [21:0] frame_number,
  output logic        missed_burst,
  output logic        start_timeout
);

  localparam int               DIV_W        = $clog2(CLOCKS_PER_QBIT);
  localparam logic [DIV_W-1:0] DIV_MAX      = DIV_W'(CLOCKS_PER_QBIT - 1);
  localparam logic [9:0]       QBIT_MAX     = 10'd624;
  localparam logic [21:0]      FN_MAX       = 22'd2715647;
  localparam logic [15:0]      TAIL_LAST    = 16'(RAMP_TAIL - 1);
  localparam logic [15:0]      TIMEOUT_LAST = 16'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WAIT_RAMP, RAMP, ACTIVE, TAIL} state_t;

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [9:0]       ramp_q;
  logic [9:0]       fire_q;
  logic [15:0]      cnt;
  logic             iq_seen;

  logic [9:0] qbit_next;
  logic [2:0] next_slot;
  logic [9:0] lead_ext;
  logic [9:0] lead_eff;
  logic [9:0] ramp_in;
  logic       slot_start;
  logic       slot_go;
  logic       ramp_hit;
  logic       fire_hit;

  assign qbit_strobe = (div == DIV_MAX);

  // Events are keyed to the strobe edge on which qbit takes the target value; a
  // zero ramp point or zero fire offset therefore lands on the slot-start edge itself.
  always_comb begin
    qbit_next  = (qbit == QBIT_MAX) ? 10'd0 : qbit + 10'd1;
    next_slot  = timeslot + 3'd1;
    lead_ext   = {2'b00, ramp_lead};
    lead_eff   = (lead_ext < fire_offset) ? lead_ext : fire_offset;
    ramp_in    = fire_offset - lead_eff;
    slot_start = qbit_strobe && (qbit == QBIT_MAX);
    slot_go    = slot_start && enable && slot_mask[next_slot] && (fire_offset <= QBIT_MAX);
    ramp_hit   = ((state == IDLE) && slot_go && (ramp_in == 10'd0)) ||
                 ((state == WAIT_RAMP) && qbit_strobe && (qbit_next == ramp_q));
    fire_hit   = ((state == IDLE) && slot_go && (fire_offset == 10'd0)) ||
                 ((state == WAIT_RAMP) && qbit_strobe && (qbit_next == ramp_q) && (ramp_q == fire_q)) ||
                 ((state == RAMP) && qbit_strobe && (qbit_next == fire_q));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div          <= '0;
      qbit         <= '0;
      timeslot     <= '0;
      frame_number <= '0;
    end else if (qbit_strobe) begin
      div  <= '0;
      qbit <= qbit_next;
      if (qbit == QBIT_MAX) begin
        timeslot <= next_slot;
        if (timeslot == 3'd7)
          frame_number <= (frame_number == FN_MAX) ? 22'd0 : frame_number + 22'd1;
      end
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      pa_en         <= 1'b0;
      fire_burst    <= 1'b0;
      missed_burst  <= 1'b0;
      start_timeout <= 1'b0;
      ramp_q        <= '0;
      fire_q        <= '0;
      cnt           <= '0;
      iq_seen       <= 1'b0;
    end else begin
      fire_burst    <= 1'b0;
      missed_burst  <= 1'b0;
      start_timeout <= 1'b0;
      if (slot_start) begin
        ramp_q <= ramp_in;
        fire_q <= fire_offset;
      end
      case (state)
        IDLE:
          if (slot_go) state <= WAIT_RAMP;
        ACTIVE:
          if (iq_seen && !iq_valid) begin
            state <= TAIL;
            cnt   <= '0;
          end else if (iq_valid) begin
            iq_seen <= 1'b1;
          end else if (qbit_strobe) begin
            if (cnt == TIMEOUT_LAST) begin
              start_timeout <= 1'b1;
              state         <= TAIL;
              cnt           <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        TAIL:
          if (qbit_strobe) begin
            if (cnt == TAIL_LAST) begin
              pa_en <= 1'b0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        default: ;
      endcase
      // Ramp and fire overrides sit after the case so both can share one edge.
      if (ramp_hit) begin
        pa_en <= 1'b1;
        state <= RAMP;
      end
      if (fire_hit) begin
        cnt     <= '0;
        iq_seen <= 1'b0;
        if (armed) begin
          fire_burst <= 1'b1;
          state      <= ACTIVE;
        end else begin
          missed_burst <= 1'b1;
          state        <= TAIL;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdma_burst_scheduler.sv
// Directed bench for tdma_burst_scheduler: timebase run, table of burst scenarios,
// frame-number wrap and asynchronous reset during a burst.
module tb_tdma_burst_scheduler;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [7:0]  slot_mask;
  logic [9:0]  fire_offset;
  logic [7:0]  ramp_lead;
  logic        armed;
  logic        iq_valid;
  logic        fire_burst;
  logic        pa_en;
  logic        qbit_strobe;
  logic [9:0]  qbit;
  logic [2:0]  timeslot;
  logic [21:0] frame_number;
  logic        missed_burst;
  logic        start_timeout;

  int total  = 0;
  int passed = 0;

  typedef struct {
    int         slot;
    logic [7:0] mask;
    logic       en;
    int         fo;
    int         lead;
    logic       arm;
    int         iq_cycles;
    int         exp_rise;
    int         exp_fire;
    int         exp_missed;
    int         exp_to;
    int         exp_fall;
    int         fall_next;
  } vec_t;

  vec_t vecs[9];

  tdma_burst_scheduler #(
    .CLOCKS_PER_QBIT(4),
    .RAMP_TAIL(2),
    .START_TIMEOUT(8)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .slot_mask(slot_mask),
    .fire_offset(fire_offset),
    .ramp_lead(ramp_lead),
    .armed(armed),
    .iq_valid(iq_valid),
    .fire_burst(fire_burst),
    .pa_en(pa_en),
    .qbit_strobe(qbit_strobe),
    .qbit(qbit),
    .timeslot(timeslot),
    .frame_number(frame_number),
    .missed_burst(missed_burst),
    .start_timeout(start_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] mask, input int fo,
                               input int lead, input logic arm);
    enable      = en;
    slot_mask   = mask;
    fire_offset = 10'(fo);
    ramp_lead   = 8'(lead);
    armed       = arm;
  endtask

  // Config is applied mid-way through the slot before the target so it is latched
  // at the target slot start, then withdrawn early in the following slot.
  task automatic runScenario(input int idx, input vec_t v);
    int   prev_slot, after_slot;
    int   rise_cnt, rise_q, rise_slot, fall_q, fall_slot;
    int   fire_cnt, fire_q, missed_cnt, missed_q, to_cnt, to_q, iq_left;
    logic pa_prev;
    bit   found, done;
    prev_slot  = (v.slot + 7) % 8;
    after_slot = (v.slot + 1) % 8;
    found = 0;
    for (int i = 0; i < 25000 && !found; i++) begin
      @(negedge clock);
      if (timeslot == 3'(prev_slot) && qbit == 10'd300) found = 1;
    end
    checkOutput($sformatf("row%0d_sync", idx), int'(found), 1);
    if (!found) return;
    applyStimulus(v.en, v.mask, v.fo, v.lead, v.arm);
    rise_cnt = 0; rise_q = -1; rise_slot = -1; fall_q = -1; fall_slot = -1;
    fire_cnt = 0; fire_q = -1; missed_cnt = 0; missed_q = -1; to_cnt = 0; to_q = -1;
    iq_left = 0; done = 0; pa_prev = pa_en;
    for (int i = 0; i < 7000 && !done; i++) begin
      @(negedge clock);
      if (pa_en && !pa_prev) begin rise_cnt++; rise_q = int'(qbit); rise_slot = int'(timeslot); end
      if (!pa_en && pa_prev) begin fall_q = int'(qbit); fall_slot = int'(timeslot); end
      pa_prev = pa_en;
      if (fire_burst)    begin fire_cnt++;   fire_q   = int'(qbit); end
      if (missed_burst)  begin missed_cnt++; missed_q = int'(qbit); end
      if (start_timeout) begin to_cnt++;     to_q     = int'(qbit); end
      if (iq_left > 0) begin
        iq_left--;
        if (iq_left == 0) iq_valid = 1'b0;
      end
      if (fire_burst && v.iq_cycles > 0) begin
        iq_valid = 1'b1;
        iq_left  = v.iq_cycles;
      end
      if (timeslot == 3'(after_slot)) begin
        if (qbit == 10'd1) applyStimulus(1'b0, 8'h00, v.fo, v.lead, v.arm);
        if (qbit == 10'd300) done = 1;
      end
    end
    iq_valid = 1'b0;
    checkOutput($sformatf("row%0d_done", idx), int'(done), 1);
    checkOutput($sformatf("row%0d_rise_count", idx), rise_cnt, (v.exp_rise >= 0) ? 1 : 0);
    checkOutput($sformatf("row%0d_rise_qbit", idx), rise_q, v.exp_rise);
    checkOutput($sformatf("row%0d_rise_slot", idx), rise_slot, (v.exp_rise >= 0) ? v.slot : -1);
    checkOutput($sformatf("row%0d_fire_cycles", idx), fire_cnt, (v.exp_fire >= 0) ? 1 : 0);
    checkOutput($sformatf("row%0d_fire_qbit", idx), fire_q, v.exp_fire);
    checkOutput($sformatf("row%0d_missed_cycles", idx), missed_cnt, (v.exp_missed >= 0) ? 1 : 0);
    checkOutput($sformatf("row%0d_missed_qbit", idx), missed_q, v.exp_missed);
    checkOutput($sformatf("row%0d_timeout_cycles", idx), to_cnt, (v.exp_to >= 0) ? 1 : 0);
    checkOutput($sformatf("row%0d_timeout_qbit", idx), to_q, v.exp_to);
    checkOutput($sformatf("row%0d_fall_qbit", idx), fall_q, v.exp_fall);
    checkOutput($sformatf("row%0d_fall_slot", idx), fall_slot,
                (v.exp_fall >= 0) ? (v.slot + v.fall_next) % 8 : -1);
    checkOutput($sformatf("row%0d_pa_end", idx), int'(pa_en), 0);
  endtask

  initial begin
    bit found;
    //          slot mask   en    fo   lead arm   iq    rise fire miss  to  fall next
    vecs[0] = '{2, 8'h04, 1'b1, 100,  10, 1'b1,  160,  90, 100,  -1,  -1, 142, 0};
    vecs[1] = '{4, 8'h10, 1'b1, 100,  10, 1'b0,    0,  90,  -1, 100,  -1, 102, 0};
    vecs[2] = '{6, 8'h40, 1'b1, 100,  10, 1'b1,    0,  90, 100,  -1, 108, 110, 0};
    vecs[3] = '{0, 8'h01, 1'b1,  50, 200, 1'b1,   20,   0,  50,  -1,  -1,  57, 0};
    vecs[4] = '{2, 8'h04, 1'b1,  50,   0, 1'b1,   12,  50,  50,  -1,  -1,  55, 0};
    vecs[5] = '{4, 8'hFF, 1'b1, 200,  10, 1'b1, 2800, 190, 200,  -1,  -1, 277, 1};
    vecs[6] = '{6, 8'h40, 1'b1, 100,  10, 1'b1,    1,  90, 100,  -1,  -1, 102, 0};
    vecs[7] = '{0, 8'h01, 1'b1, 700,  10, 1'b1,    0,  -1,  -1,  -1,  -1,  -1, 0};
    vecs[8] = '{2, 8'h04, 1'b0, 100,  10, 1'b1,    0,  -1,  -1,  -1,  -1,  -1, 0};

    reset_n  = 1'b0;
    iq_valid = 1'b0;
    applyStimulus(1'b0, 8'h00, 0, 0, 1'b0);
    repeat (2) @(negedge clock);
    checkOutput("reset_pa_en", int'(pa_en), 0);
    checkOutput("reset_fire", int'(fire_burst), 0);
    checkOutput("reset_missed", int'(missed_burst), 0);
    checkOutput("reset_timeout", int'(start_timeout), 0);
    checkOutput("reset_strobe", int'(qbit_strobe), 0);
    checkOutput("reset_qbit", int'(qbit), 0);
    checkOutput("reset_slot", int'(timeslot), 0);
    checkOutput("reset_fn", int'(frame_number), 0);
    reset_n = 1'b1;

    // Free run: sample after each rising edge k counted from reset release.
    for (int k = 1; k <= 20000; k++) begin
      @(negedge clock);
      if (k <= 12) checkOutput($sformatf("strobe_edge%0d", k), int'(qbit_strobe), (k % 4 == 3) ? 1 : 0);
      if (k == 2499) checkOutput("slot_before_2500", int'(timeslot), 0);
      if (k == 2500) begin
        checkOutput("slot_at_2500", int'(timeslot), 1);
        checkOutput("qbit_at_2500", int'(qbit), 0);
      end
      if (k == 19999) begin
        checkOutput("fn_before_20000", int'(frame_number), 0);
        checkOutput("qbit_before_20000", int'(qbit), 624);
      end
      if (k == 20000) begin
        checkOutput("fn_at_20000", int'(frame_number), 1);
        checkOutput("slot_at_20000", int'(timeslot), 0);
      end
    end

    for (int i = 0; i < 9; i++) runScenario(i, vecs[i]);

    // Frame number wrap: preload the last quarter-bit of the last frame.
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clock);
      if (qbit_strobe) found = 1;
    end
    checkOutput("wrap_strobe_found", int'(found), 1);
    force dut.frame_number = 22'd2715647;
    force dut.timeslot     = 3'd7;
    force dut.qbit         = 10'd624;
    #1;
    release dut.frame_number;
    release dut.timeslot;
    release dut.qbit;
    @(negedge clock);
    checkOutput("wrap_fn", int'(frame_number), 0);
    checkOutput("wrap_slot", int'(timeslot), 0);
    checkOutput("wrap_qbit", int'(qbit), 0);

    // Asynchronous reset while the PA is on.
    applyStimulus(1'b1, 8'hFF, 100, 10, 1'b1);
    found = 0;
    for (int i = 0; i < 6000 && !found; i++) begin
      @(negedge clock);
      if (pa_en) found = 1;
    end
    checkOutput("rst_pa_seen", int'(found), 1);
    applyStimulus(1'b0, 8'h00, 100, 10, 1'b1);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_pa_drop", int'(pa_en), 0);
    checkOutput("rst_qbit", int'(qbit), 0);
    checkOutput("rst_slot", int'(timeslot), 0);
    checkOutput("rst_fn", int'(frame_number), 0);
    checkOutput("rst_strobe", int'(qbit_strobe), 0);
    repeat (3) @(negedge clock);
    checkOutput("rst_hold_pa", int'(pa_en), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    checkOutput("post_rst_qbit", int'(qbit), 1);
    checkOutput("post_rst_pa", int'(pa_en), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
